// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and traps on illegal opcodes or memory handshake timeouts.
module multicycle_controller #(
    parameter int OPCODE_WIDTH    = 7,
    parameter int ALU_SRC_B_WIDTH = 2,
    parameter int TIMEOUT         = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OPCODE_WIDTH-1:0]    opCode,
    input  logic                       branchTaken,
    input  logic                       memReady,
    output logic                       PCWrite,
    output logic                       IRWrite,
    output logic                       ALUSrcA,
    output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
    output logic                       regFileWrite,
    output logic                       memReq,
    output logic                       memWrite,
    output logic                       memToReg,
    output logic                       trap
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_OP, C_IMM, C_LOAD, C_STORE, C_BR, C_JAL, C_LUI
    } class_t;

    localparam logic [OPCODE_WIDTH-1:0] OPC_OP    = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_IMM   = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BR    = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL   = OPCODE_WIDTH'(7'b1101111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI   = OPCODE_WIDTH'(7'b0110111);

    localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_REG = '0;
    localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_4   = ALU_SRC_B_WIDTH'(1);
    localparam logic [ALU_SRC_B_WIDTH-1:0] SRCB_IMM = ALU_SRC_B_WIDTH'(2);

    state_t     r_state;
    state_t     w_next;
    class_t     r_class;
    class_t     w_class;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] w_cnt_inc;
    logic       w_ready;
    logic       w_timeout;

    // memReady is masked during reset so outputs show a waiting FETCH
    assign w_ready   = memReady & ~rst;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == 8'(TIMEOUT));

    // Opcode class decode
    always_comb begin
        w_class = C_ILL;
        case (opCode)
            OPC_OP:    w_class = C_OP;
            OPC_IMM:   w_class = C_IMM;
            OPC_LOAD:  w_class = C_LOAD;
            OPC_STORE: w_class = C_STORE;
            OPC_BR:    w_class = C_BR;
            OPC_JAL:   w_class = C_JAL;
            OPC_LUI:   w_class = C_LUI;
            default:   w_class = C_ILL;
        endcase
    end

    // State, wait counter and latched class registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= 8'd0;
            r_class <= C_ILL;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_DECODE)
                r_class <= w_class;
        end
    end

    // Next-state, counter and control output logic
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = 8'd0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        regFileWrite = 1'b0;
        memReq       = 1'b0;
        memWrite     = 1'b0;
        memToReg     = 1'b0;
        trap         = 1'b0;
        case (r_state)
            S_FETCH: begin
                memReq  = 1'b1;
                ALUSrcB = SRCB_4;
                if (w_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
                w_next  = (w_class == C_ILL) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (r_class)
                    C_OP: begin
                        ALUSrcA = 1'b1;
                        w_next  = S_WRITEBACK;
                    end
                    C_IMM: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMM;
                        w_next  = S_WRITEBACK;
                    end
                    C_LOAD, C_STORE: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMM;
                        w_next  = S_MEMORY;
                    end
                    C_LUI: begin
                        ALUSrcB = SRCB_IMM;
                        w_next  = S_WRITEBACK;
                    end
                    C_BR: begin
                        ALUSrcA = 1'b1;
                        PCWrite = branchTaken;
                        w_next  = S_FETCH;
                    end
                    C_JAL: begin
                        PCWrite = 1'b1;
                        w_next  = S_WRITEBACK;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEMORY: begin
                memReq   = 1'b1;
                memWrite = (r_class == C_STORE);
                if (w_ready) begin
                    w_next = (r_class == C_STORE) ? S_FETCH : S_WRITEBACK;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_WRITEBACK: begin
                regFileWrite = 1'b1;
                memToReg     = (r_class == C_LOAD);
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected control vectors
// are queued per cycle and compared by an independent monitor.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opCode;
    logic       branchTaken;
    logic       memReady;
    logic       PCWrite, IRWrite, ALUSrcA, regFileWrite;
    logic       memReq, memWrite, memToReg, trap;
    logic [1:0] ALUSrcB;

    multicycle_controller #(
        .OPCODE_WIDTH(7), .ALU_SRC_B_WIDTH(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .opCode(opCode),
        .branchTaken(branchTaken), .memReady(memReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .regFileWrite(regFileWrite),
        .memReq(memReq), .memWrite(memWrite), .memToReg(memToReg),
        .trap(trap)
    );

    // {PCWrite, IRWrite, ALUSrcA, ALUSrcB, regFileWrite, memReq, memWrite, memToReg, trap}
    localparam logic [9:0] V_F_WAIT = 10'b0_0_0_01_0_1_0_0_0;
    localparam logic [9:0] V_F_GO   = 10'b1_1_0_01_0_1_0_0_0;
    localparam logic [9:0] V_DEC    = 10'b0_0_0_10_0_0_0_0_0;
    localparam logic [9:0] V_EX_OP  = 10'b0_0_1_00_0_0_0_0_0;
    localparam logic [9:0] V_EX_IMM = 10'b0_0_1_10_0_0_0_0_0;
    localparam logic [9:0] V_EX_LUI = 10'b0_0_0_10_0_0_0_0_0;
    localparam logic [9:0] V_EX_BRT = 10'b1_0_1_00_0_0_0_0_0;
    localparam logic [9:0] V_EX_BRN = 10'b0_0_1_00_0_0_0_0_0;
    localparam logic [9:0] V_EX_JAL = 10'b1_0_0_00_0_0_0_0_0;
    localparam logic [9:0] V_MEM_LD = 10'b0_0_0_00_0_1_0_0_0;
    localparam logic [9:0] V_MEM_ST = 10'b0_0_0_00_0_1_1_0_0;
    localparam logic [9:0] V_WB     = 10'b0_0_0_00_1_0_0_0_0;
    localparam logic [9:0] V_WB_LD  = 10'b0_0_0_00_1_0_0_1_0;
    localparam logic [9:0] V_TRAP   = 10'b0_0_0_00_0_0_0_0_1;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue the expectation
    task automatic step(input logic r, input logic [6:0] op, input logic bt,
                        input logic mr, input logic [9:0] e, input string nm);
        rst         = r;
        opCode      = op;
        branchTaken = bt;
        memReady    = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented control vector mid-cycle
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] e;
        string      nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {PCWrite, IRWrite, ALUSrcA, ALUSrcB, regFileWrite,
                   memReq, memWrite, memToReg, trap};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", nm, got, e);
            end
        end
    end

    initial begin
        rst = 1'b1; opCode = OP; branchTaken = 1'b0; memReady = 1'b0;
        @(posedge clk); #1;
        step(1, OP, 0, 1, V_F_WAIT, "rst_outputs");

        step(0, OP, 0, 1, V_F_GO,  "op_fetch");
        step(0, OP, 0, 1, V_DEC,   "op_decode");
        step(0, OP, 0, 1, V_EX_OP, "op_exec");
        step(0, OP, 0, 1, V_WB,    "op_wb");

        step(0, IMM, 0, 1, V_F_GO,   "imm_fetch");
        step(0, IMM, 0, 1, V_DEC,    "imm_decode");
        step(0, IMM, 0, 1, V_EX_IMM, "imm_exec");
        step(0, IMM, 0, 1, V_WB,     "imm_wb");

        step(0, LUI, 0, 1, V_F_GO,   "lui_fetch");
        step(0, LUI, 0, 1, V_DEC,    "lui_decode");
        step(0, ST,  0, 1, V_EX_LUI, "lui_exec_latched");
        step(0, ST,  0, 1, V_WB,     "lui_wb_latched");

        step(0, JAL, 0, 1, V_F_GO,   "jal_fetch");
        step(0, JAL, 0, 0, V_DEC,    "jal_decode_rdy_ignored");
        step(0, JAL, 0, 0, V_EX_JAL, "jal_exec");
        step(0, JAL, 0, 0, V_WB,     "jal_wb");

        step(0, LD, 0, 1, V_F_GO,   "ld_fetch");
        step(0, LD, 0, 1, V_DEC,    "ld_decode");
        step(0, LD, 0, 1, V_EX_IMM, "ld_exec");
        step(0, LD, 0, 0, V_MEM_LD, "ld_mem_w1");
        step(0, LD, 0, 0, V_MEM_LD, "ld_mem_w2");
        step(0, LD, 0, 0, V_MEM_LD, "ld_mem_w3");
        step(0, LD, 0, 1, V_MEM_LD, "ld_mem_done");
        step(0, LD, 0, 1, V_WB_LD,  "ld_wb");

        step(0, ST, 0, 1, V_F_GO,   "st_fetch");
        step(0, ST, 0, 1, V_DEC,    "st_decode");
        step(0, ST, 0, 1, V_EX_IMM, "st_exec");
        step(0, ST, 0, 1, V_MEM_ST, "st_mem");

        step(0, BR, 1, 1, V_F_GO,   "brt_fetch");
        step(0, BR, 1, 1, V_DEC,    "brt_decode");
        step(0, BR, 1, 1, V_EX_BRT, "brt_exec");
        step(0, BR, 0, 1, V_F_GO,   "brn_fetch");
        step(0, BR, 0, 1, V_DEC,    "brn_decode");
        step(0, BR, 0, 1, V_EX_BRN, "brn_exec");

        step(0, OP, 0, 0, V_F_WAIT, "to_ok_w1");
        step(0, OP, 0, 0, V_F_WAIT, "to_ok_w2");
        step(0, OP, 0, 0, V_F_WAIT, "to_ok_w3");
        step(0, OP, 0, 1, V_F_GO,   "to_ok_last_cycle");
        step(0, OP, 0, 1, V_DEC,    "to_ok_decode");
        step(0, OP, 0, 1, V_EX_OP,  "to_ok_exec");
        step(0, OP, 0, 1, V_WB,     "to_ok_wb");

        for (int i = 0; i < 4; i++)
            step(0, OP, 0, 0, V_F_WAIT, "to_trap_wait");
        for (int i = 0; i < 3; i++)
            step(0, OP, 0, 1, V_TRAP, "to_trap_sticky");
        step(1, OP, 0, 1, V_F_WAIT, "to_trap_rst");

        step(0, BAD, 0, 1, V_F_GO, "ill_fetch");
        step(0, BAD, 0, 1, V_DEC,  "ill_decode");
        for (int i = 0; i < 20; i++)
            step(0, (i % 2 == 0) ? OP : BAD, i[0], 1, V_TRAP, "ill_trap_hold");
        step(1, OP, 0, 1, V_F_WAIT, "ill_rst");

        step(0, ST, 0, 1, V_F_GO,   "rst_st_fetch");
        step(0, ST, 0, 1, V_DEC,    "rst_st_decode");
        step(0, ST, 0, 1, V_EX_IMM, "rst_st_exec");
        step(0, ST, 0, 0, V_MEM_ST, "rst_st_mem");
        step(1, ST, 0, 1, V_F_WAIT, "rst_st_async");
        step(0, OP, 0, 1, V_F_GO,   "post_rst_fetch");
        step(0, OP, 0, 1, V_DEC,    "post_rst_decode");
        step(0, OP, 0, 1, V_EX_OP,  "post_rst_exec");
        step(0, OP, 0, 1, V_WB,     "post_rst_wb");
        step(0, OP, 0, 0, V_F_WAIT, "post_rst_refetch");

        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pending expectations, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
